// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, hold buffer for Decode stalls.
// Optional fetch abort on memory timeout is enabled with the FETCH_TIMEOUT_EN macro.
module fetch_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic        stall_d_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_f_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] hold_r;
    logic [31:0] last_r;
    logic        deliver_s;
    logic        from_hold_s;
    logic        capture_s;
    logic        to_s;
    logic [31:0] instr_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_r;
    logic          in_wait_s;
    logic          stay_wait_s;

    assign in_wait_s   = (state_r == WAIT) || (state_r == DROP);
    assign stay_wait_s = (state_next_s == WAIT) || (state_next_s == DROP);
    assign to_s        = in_wait_s && (cnt_r == CW'(TIMEOUT_CYCLES));

    // Cycles spent waiting for a response; clears when the wait states are left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (in_wait_s && stay_wait_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= '0;
        end
    end
`else
    assign to_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and delivery decode; a timeout abort outranks any response
    always_comb begin
        state_next_s = state_r;
        deliver_s    = 1'b0;
        from_hold_s  = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: state_next_s = REQ;
            REQ: begin
                if (mem_gnt_i) begin
                    state_next_s = redirect_i ? DROP : WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (to_s) begin
                    state_next_s = REQ;
                end else if (mem_rvalid_i) begin
                    if (redirect_i) begin
                        state_next_s = REQ;
                    end else if (!stall_d_i) begin
                        deliver_s    = 1'b1;
                        state_next_s = REQ;
                    end else begin
                        capture_s    = 1'b1;
                        state_next_s = HOLD;
                    end
                end else if (redirect_i) begin
                    state_next_s = DROP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    state_next_s = REQ;
                end else if (!stall_d_i) begin
                    deliver_s    = 1'b1;
                    from_hold_s  = 1'b1;
                    state_next_s = REQ;
                end else begin
                    state_next_s = HOLD;
                end
            end
            DROP: begin
                if (to_s || mem_rvalid_i) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = DROP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode; IDLE (held during reset) keeps the PC frozen even under redirect
    always_comb begin
        if (deliver_s) begin
            instr_s = from_hold_s ? hold_r : mem_rdata_i;
        end else begin
            instr_s = last_r;
        end
        if (state_r == IDLE) begin
            stall_f_o = 1'b1;
        end else if (redirect_i) begin
            stall_f_o = 1'b0;
        end else begin
            stall_f_o = !deliver_s;
        end
    end

    assign mem_req_o     = (state_r == REQ);
    assign mem_addr_o    = pc_i;
    assign instr_o       = instr_s;
    assign instr_valid_o = deliver_s;
    assign timeout_o     = to_s;

    // Hold buffer for stalled responses and the last instruction presented to Decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= 32'd0;
            last_r <= 32'd0;
        end else begin
            if (capture_s) begin
                hold_r <= mem_rdata_i;
            end
            if (deliver_s) begin
                last_r <= instr_s;
            end
        end
    end

endmodule
